aes_key_expansion: RTL and testbench

- AES-128 key schedule generator; the producer of the round_key / key-valid stream that the AddRoundKey stage consumes.
- Accepts one cipher key and emits round keys 0..NR in order, one per accepted handshake, with backpressure.
- Sits between the key load interface and the round datapath.
- Iterative: one key-schedule step per cycle, no full unrolling.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes_key_expansion.sv | 176 +++++++++++++++++
 tb/tb_aes_key_expansion.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the AES-128 key schedule.
package aes_pkg;

  localparam int         DATA_W_DEFAULT = 128;
  localparam int         NR_DEFAULT     = 10;
  localparam logic [7:0] RCON_INIT      = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_FINISH,
    ST_PRECOMPUTE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_inv;

  // a^254 is the inverse for non-zero a and maps 0 to 0, which is what the S-box wants.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] res;
    logic [7:0] pw;
    res = 8'h01;
    pw  = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) res = gf_mul(res, pw);
      pw = gf_mul(pw, pw);
    end
    return res;
  endfunction

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule streaming round keys 0..NR with a valid/ready handshake.
// Define AES_KEYEXP_DECRYPT_EN to add decrypt_in and reverse-order emission from a key store.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int NR     = NR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid_in,
  input  logic [DATA_W-1:0] key_in,
`ifdef AES_KEYEXP_DECRYPT_EN
  input  logic              decrypt_in,
`endif
  input  logic              key_ready_in,
  output logic              key_valid_out,
  output logic [DATA_W-1:0] round_key,
  output logic [3:0]        round_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_round_key, w_key_next;
  logic [3:0]        r_round_idx, w_idx_next;
  logic              r_valid, w_valid_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic [7:0]        r_rcon, w_rcon_next;

  logic [31:0]       w_rot, w_sub, w_t;
  logic [31:0]       w_n0, w_n1, w_n2, w_n3;
  logic [DATA_W-1:0] w_step_key;
  logic              w_handshake;

`ifdef AES_KEYEXP_DECRYPT_EN
  logic              r_decrypt, w_decrypt_next;
  logic [3:0]        r_pidx, w_pidx_next;
  logic [DATA_W-1:0] r_store [0:NR];
`endif

  assign w_rot = {r_round_key[23:0], r_round_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_t        = w_sub ^ {r_rcon, 24'h0};
  assign w_n0       = r_round_key[127:96] ^ w_t;
  assign w_n1       = r_round_key[95:64]  ^ w_n0;
  assign w_n2       = r_round_key[63:32]  ^ w_n1;
  assign w_n3       = r_round_key[31:0]   ^ w_n2;
  assign w_step_key = {w_n0, w_n1, w_n2, w_n3};
  assign w_handshake = r_valid & key_ready_in;

  always_comb begin
    w_state_next = r_state;
    w_key_next   = r_round_key;
    w_idx_next   = r_round_idx;
    w_valid_next = r_valid;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_rcon_next  = r_rcon;
`ifdef AES_KEYEXP_DECRYPT_EN
    w_decrypt_next = r_decrypt;
    w_pidx_next    = r_pidx;
`endif
    case (r_state)
      ST_IDLE: begin
        if (key_valid_in) begin
          w_key_next   = key_in;
          w_idx_next   = 4'd0;
          w_rcon_next  = RCON_INIT;
          w_busy_next  = 1'b1;
          w_state_next = ST_EMIT;
          w_valid_next = 1'b1;
`ifdef AES_KEYEXP_DECRYPT_EN
          w_decrypt_next = decrypt_in;
          w_pidx_next    = 4'd0;
          if (decrypt_in) begin
            w_state_next = ST_PRECOMPUTE;
            w_valid_next = 1'b0;
          end
`endif
        end
      end
`ifdef AES_KEYEXP_DECRYPT_EN
      // The working key register walks forward while the store captures each round key.
      ST_PRECOMPUTE: begin
        if (r_pidx == LAST_IDX) begin
          w_idx_next   = LAST_IDX;
          w_valid_next = 1'b1;
          w_state_next = ST_EMIT;
        end else begin
          w_key_next  = w_step_key;
          w_rcon_next = xtime(r_rcon);
          w_pidx_next = r_pidx + 4'd1;
        end
      end
`endif
      ST_EMIT: begin
        if (w_handshake) begin
`ifdef AES_KEYEXP_DECRYPT_EN
          if (r_decrypt ? (r_round_idx == 4'd0) : (r_round_idx == LAST_IDX)) begin
`else
          if (r_round_idx == LAST_IDX) begin
`endif
            w_valid_next = 1'b0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_state_next = ST_FINISH;
`ifdef AES_KEYEXP_DECRYPT_EN
          end else if (r_decrypt) begin
            w_key_next = r_store[r_round_idx - 4'd1];
            w_idx_next = r_round_idx - 4'd1;
`endif
          end else begin
            w_key_next  = w_step_key;
            w_idx_next  = r_round_idx + 4'd1;
            w_rcon_next = xtime(r_rcon);
          end
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_round_key <= '0;
      r_round_idx <= 4'd0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rcon      <= RCON_INIT;
`ifdef AES_KEYEXP_DECRYPT_EN
      r_decrypt   <= 1'b0;
      r_pidx      <= 4'd0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_round_key <= w_key_next;
      r_round_idx <= w_idx_next;
      r_valid     <= w_valid_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_rcon      <= w_rcon_next;
`ifdef AES_KEYEXP_DECRYPT_EN
      r_decrypt   <= w_decrypt_next;
      r_pidx      <= w_pidx_next;
`endif
    end
  end

`ifdef AES_KEYEXP_DECRYPT_EN
  // Store contents are always rewritten before they are read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (r_state == ST_PRECOMPUTE) r_store[r_pidx] <= r_round_key;
  end
`endif

  assign key_valid_out = r_valid;
  assign round_key     = r_round_key;
  assign round_idx     = r_round_idx;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion against a word-oriented key schedule model.
module tb_aes_key_expansion;

  logic         clk;
  logic         reset;
  logic         key_valid_in;
  logic [127:0] key_in;
  logic         key_ready_in;
  logic         key_valid_out;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
`ifdef AES_KEYEXP_DECRYPT_EN
  logic         decrypt_in;
`endif

  int           tests;
  int           fails;
  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_keys [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R4  = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [127:0] FIPS_R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_key_expansion dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid_in  (key_valid_in),
    .key_in        (key_in),
`ifdef AES_KEYEXP_DECRYPT_EN
    .decrypt_in    (decrypt_in),
`endif
    .key_ready_in  (key_ready_in),
    .key_valid_out (key_valid_out),
    .round_key     (round_key),
    .round_idx     (round_idx),
    .busy          (busy),
    .done          (done)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial multiply then reduce modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (prod[k]) prod = prod ^ (16'h011b << (k - 8));
    return prod[7:0];
  endfunction

  // Build the S-box table by brute-force inverse search plus the bitwise affine rule.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  // FIPS-197 word-wise key expansion into exp_keys[0..10].
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = ref_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] key);
    key_valid_in = 1'b1;
    key_in       = key;
    tick();
    key_valid_in = 1'b0;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #2;
    tests++; if (key_valid_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got=%b want=0", key_valid_out); end
    tests++; if (round_key !== 128'h0) begin fails++; $display("[TB] FAIL reset_key got=%h want=0", round_key); end
    tests++; if (round_idx !== 4'd0) begin fails++; $display("[TB] FAIL reset_idx got=%0d want=0", round_idx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fips_forward();
    expand(FIPS_KEY);
    key_ready_in = 1'b1;
    start(FIPS_KEY);
    for (int r = 0; r <= 10; r++) begin
      tests++;
      if (key_valid_out !== 1'b1 || round_idx !== 4'(r) || round_key !== exp_keys[r] || busy !== 1'b1) begin
        fails++; $display("[TB] FAIL fwd_round%0d got v=%b idx=%0d key=%h busy=%b want idx=%0d key=%h", r, key_valid_out, round_idx, round_key, busy, r, exp_keys[r]);
      end
      if (r == 0) begin tests++; if (round_key !== FIPS_KEY) begin fails++; $display("[TB] FAIL fips_r0 got=%h want=%h", round_key, FIPS_KEY); end end
      if (r == 1) begin tests++; if (round_key !== FIPS_R1) begin fails++; $display("[TB] FAIL fips_r1 got=%h want=%h", round_key, FIPS_R1); end end
      if (r == 10) begin tests++; if (round_key !== FIPS_R10) begin fails++; $display("[TB] FAIL fips_r10 got=%h want=%h", round_key, FIPS_R10); end end
      tick();
    end
    tests++;
    if (done !== 1'b1 || key_valid_out !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL fwd_done got done=%b v=%b busy=%b want 1/0/0", done, key_valid_out, busy);
    end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL fwd_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_backpressure();
    expand(FIPS_KEY);
    key_ready_in = 1'b1;
    start(FIPS_KEY);
    for (int r = 0; r < 4; r++) tick();
    key_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (key_valid_out !== 1'b1 || round_idx !== 4'd4 || round_key !== FIPS_R4) begin
        fails++; $display("[TB] FAIL bp_hold%0d got v=%b idx=%0d key=%h want idx=4 key=%h", c, key_valid_out, round_idx, round_key, FIPS_R4);
      end
    end
    key_ready_in = 1'b1;
    tick();
    tests++;
    if (round_idx !== 4'd5 || round_key !== FIPS_R5) begin
      fails++; $display("[TB] FAIL bp_resume got idx=%0d key=%h want idx=5 key=%h", round_idx, round_key, FIPS_R5);
    end
    for (int r = 5; r <= 10; r++) tick();
    tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL bp_done got=%b want=1", done); end
    tick();
  endtask

  task automatic test_start_while_busy();
    expand(FIPS_KEY);
    key_ready_in = 1'b1;
    start(FIPS_KEY);
    for (int r = 0; r <= 10; r++) begin
      tests++;
      if (key_valid_out !== 1'b1 || round_idx !== 4'(r) || round_key !== exp_keys[r]) begin
        fails++; $display("[TB] FAIL busy_round%0d got idx=%0d key=%h want=%h", r, round_idx, round_key, exp_keys[r]);
      end
      if (r == 3) begin key_valid_in = 1'b1; key_in = 128'h0; end
      tick();
      key_valid_in = 1'b0;
    end
    key_valid_in = 1'b1;
    key_in       = rand_key();
    tick();
    key_valid_in = 1'b0;
    tests++;
    if (key_valid_out !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL finish_start_ignored got v=%b busy=%b want 0/0", key_valid_out, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    expand(FIPS_KEY);
    key_ready_in = 1'b1;
    start(FIPS_KEY);
    for (int r = 0; r < 6; r++) tick();
    #2 reset = 1'b0;
    #1;
    tests++;
    if (key_valid_out !== 1'b0 || round_key !== 128'h0 || round_idx !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_reset got v=%b key=%h idx=%0d busy=%b done=%b want all 0", key_valid_out, round_key, round_idx, busy, done);
    end
    #2 reset = 1'b1;
    tick();
    k = rand_key();
    expand(k);
    start(k);
    for (int r = 0; r <= 10; r++) begin
      tests++;
      if (key_valid_out !== 1'b1 || round_idx !== 4'(r) || round_key !== exp_keys[r]) begin
        fails++; $display("[TB] FAIL post_reset_round%0d got idx=%0d key=%h want=%h", r, round_idx, round_key, exp_keys[r]);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_back_to_back_random();
    logic [127:0] k;
    logic         rdy;
    int           idx;
    int           cyc;
    for (int n = 0; n < 4; n++) begin
      k = rand_key();
      expand(k);
      start(k);
      idx = 0;
      cyc = 0;
      while (idx <= 10 && cyc < 300) begin
        tests++;
        if (key_valid_out !== 1'b1 || round_idx !== 4'(idx) || round_key !== exp_keys[idx]) begin
          fails++; $display("[TB] FAIL rand%0d_round%0d got v=%b idx=%0d key=%h want=%h", n, idx, key_valid_out, round_idx, round_key, exp_keys[idx]);
        end
        rdy = ($urandom_range(0, 3) != 0);
        key_ready_in = rdy;
        tick();
        if (rdy) idx++;
        cyc++;
      end
      tests++; if (idx != 11) begin fails++; $display("[TB] FAIL rand%0d_timeout got idx=%0d want=11", n, idx); end
      tests++;
      if (done !== 1'b1 || key_valid_out !== 1'b0) begin
        fails++; $display("[TB] FAIL rand%0d_done got done=%b v=%b want 1/0", n, done, key_valid_out);
      end
      key_ready_in = 1'b1;
      tick();
    end
  endtask

`ifdef AES_KEYEXP_DECRYPT_EN
  task automatic test_decrypt();
    expand(FIPS_KEY);
    key_ready_in = 1'b1;
    decrypt_in   = 1'b1;
    start(FIPS_KEY);
    decrypt_in   = 1'b0;
    for (int c = 0; c < 11; c++) begin
      tests++;
      if (key_valid_out !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("[TB] FAIL dec_silent%0d got v=%b busy=%b want 0/1", c, key_valid_out, busy);
      end
      tick();
    end
    for (int r = 10; r >= 0; r--) begin
      tests++;
      if (key_valid_out !== 1'b1 || round_idx !== 4'(r) || round_key !== exp_keys[r]) begin
        fails++; $display("[TB] FAIL dec_round%0d got v=%b idx=%0d key=%h want=%h", r, key_valid_out, round_idx, round_key, exp_keys[r]);
      end
      if (r == 10) begin tests++; if (round_key !== FIPS_R10) begin fails++; $display("[TB] FAIL dec_first got=%h want=%h", round_key, FIPS_R10); end end
      if (r == 0) begin tests++; if (round_key !== FIPS_KEY) begin fails++; $display("[TB] FAIL dec_last got=%h want=%h", round_key, FIPS_KEY); end end
      tick();
    end
    tests++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL dec_done got=%b want=1", done); end
    tick();
  endtask
`endif

  // Hard stop in case the DUT wedges a bounded loop's surroundings.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests        = 0;
    fails        = 0;
    key_valid_in = 1'b0;
    key_in       = '0;
    key_ready_in = 1'b0;
`ifdef AES_KEYEXP_DECRYPT_EN
    decrypt_in   = 1'b0;
`endif
    build_sbox();
    test_reset();
    test_fips_forward();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back_random();
`ifdef AES_KEYEXP_DECRYPT_EN
    test_decrypt();
    test_fips_forward();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
